// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
// Holds the FSM state encoding, default sizing and the rotate helper.
package arb_pkg;

  localparam int NUM_REQ_DEF = 8;
  localparam int VEC_W       = 32;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  // Rotate the low w bits of vec left by n, so bit i lands at (i+n) mod w.
  function automatic logic [VEC_W-1:0] rot_left(
    input logic [VEC_W-1:0] vec,
    input int               n,
    input int               w
  );
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (i < w) r[(i + n) % w] = vec[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: descending from start, wrapping.
// With rr low the search always starts at the top index.
module arb_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  input  logic               rr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [VEC_W-1:0] rot;
  int               st;
  int               hi;

  // Rotate so the start index sits on top, then take the highest set bit.
  always_comb begin
    st  = rr ? int'(start) : NUM_REQ - 1;
    rot = rot_left(VEC_W'(req), NUM_REQ - 1 - st, NUM_REQ);
    hi  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot[i]) hi = i;
    end
    any = |req;
    idx = ID_W'((hi + st + 1) % NUM_REQ);
  end

endmodule

// File: rtl/req_arbiter.sv
// One-resource arbiter with registered one-hot grant.
// Fixed-priority or round-robin pick, with done/drop/hold-limit release.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               cfg_rr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               tmo_q, tmo_d;

  logic [ID_W-1:0]    start;
  logic               any;
  logic [ID_W-1:0]    idx;
  logic               lim;
  logic               rel;

  // Last holder gets lowest priority: search starts just below ptr.
  assign start = (ptr_q == '0) ? ID_W'(NUM_REQ - 1)
                               : ptr_q - 1'b1;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .start (start),
    .rr    (cfg_rr),
    .any   (any),
    .idx   (idx)
  );

  assign lim = (MAX_HOLD != 0) &&
               (hold_q == HW'(MAX_HOLD - 1));
  assign rel = done | ~req[id_q] | lim;

  // Next-state, grant and counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (any) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << idx;
          id_d    = idx;
          hold_d  = '0;
          if (cfg_rr) ptr_d = idx;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          tmo_d   = lim & ~done & req[id_q];
        end else if (hold_q != {HW{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed testbench for req_arbiter (MAX_HOLD=4).
// Each task drives a scenario and checks hand-computed values.
module tb_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       cfg_rr;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk;
  int n_err;

  req_arbiter #(
    .NUM_REQ  (8),
    .ID_W     (3),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .cfg_rr    (cfg_rr),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req    = 8'hFF;
    done   = 1'b0;
    cfg_rr = 1'b0;
    step();
    step();
    n_chk++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold gnt=%h v=%b t=%b want 00/0/0",
               gnt, gnt_valid, timeout);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first gnt=%h id=%0d v=%b want 80/7/1",
               gnt, gnt_id, gnt_valid);
    end
    req = 8'h00;
    step();
    n_chk++;
    if (gnt !== 8'h00 || timeout !== 1'b0 || gnt_id !== 3'd7) begin
      n_err++;
      $display("FAIL reset_drop gnt=%h t=%b id=%0d want 00/0/7",
               gnt, timeout, gnt_id);
    end
  endtask

  task automatic test_fixed();
    cfg_rr = 1'b0;
    req    = 8'b1000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
        n_err++;
        $display("FAIL fixed_gnt%0d gnt=%h id=%0d want 80/7",
                 i, gnt, gnt_id);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_chk++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL fixed_idle%0d gnt=%h v=%b t=%b want 00/0/0",
                 i, gnt, gnt_valid, timeout);
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id;
    cfg_rr = 1'b1;
    req    = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      exp_id = 3'((7 - i) & 7);
      step();
      n_chk++;
      if (gnt_id !== exp_id || gnt !== (8'h01 << exp_id)) begin
        n_err++;
        $display("FAIL rr_seq%0d gnt=%h id=%0d want id %0d",
                 i, gnt, gnt_id, exp_id);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_chk++;
      if (gnt !== 8'h00) begin
        n_err++;
        $display("FAIL rr_gap%0d gnt=%h want 00", i, gnt);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_hold_limit();
    cfg_rr = 1'b1;
    req    = 8'h09;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (gnt_id !== 3'd3 || gnt !== 8'h08 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL lim_hold%0d gnt=%h id=%0d t=%b want 08/3/0",
                 i, gnt, gnt_id, timeout);
      end
    end
    step();
    n_chk++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_id !== 3'd3) begin
      n_err++;
      $display("FAIL lim_revoke gnt=%h t=%b id=%0d want 00/1/3",
               gnt, timeout, gnt_id);
    end
    step();
    n_chk++;
    if (gnt_id !== 3'd0 || gnt !== 8'h01 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL lim_next gnt=%h id=%0d t=%b want 01/0/0",
               gnt, gnt_id, timeout);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_drop();
    cfg_rr = 1'b1;
    req    = 8'h30;
    step();
    n_chk++;
    if (gnt_id !== 3'd5 || gnt !== 8'h20) begin
      n_err++;
      $display("FAIL drop_gnt gnt=%h id=%0d want 20/5", gnt, gnt_id);
    end
    step();
    req = 8'h10;
    step();
    n_chk++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL drop_rel gnt=%h t=%b want 00/0", gnt, timeout);
    end
    step();
    n_chk++;
    if (gnt_id !== 3'd4 || gnt !== 8'h10) begin
      n_err++;
      $display("FAIL drop_next gnt=%h id=%0d want 10/4", gnt, gnt_id);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_done_at_limit();
    cfg_rr = 1'b0;
    req    = 8'h02;
    step();
    step();
    step();
    step();
    n_chk++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      n_err++;
      $display("FAIL dlim_hold gnt=%h id=%0d want 02/1", gnt, gnt_id);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_chk++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL dlim_rel gnt=%h t=%b want 00/0", gnt, timeout);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    cfg_rr = 1'b1;
    req    = 8'hFF;
    step();
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ar_pre v=%b want 1", gnt_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      n_err++;
      $display("FAIL ar_drop gnt=%h v=%b id=%0d want 00/0/0",
               gnt, gnt_valid, gnt_id);
    end
    step();
    req   = 8'h81;
    rst_n = 1'b1;
    step();
    n_chk++;
    if (gnt_id !== 3'd7 || gnt !== 8'h80) begin
      n_err++;
      $display("FAIL ar_after gnt=%h id=%0d want 80/7", gnt, gnt_id);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_hold_limit();
    test_drop();
    test_done_at_limit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
